id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 16-bit CPU, directly upstream of the ALU.
- Registers decoded operands and control from ID.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards: stalls IF/ID and inserts a bubble. Flushes on a taken branch.
- Presents the final ALUOp/A/B to the ALU every cycle.

Parameters:
- DATA_W, 16, operand/result width.
- RADDR_W, 3, register index width (8 GPRs; r0 reads as zero, never a forwarding source).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_ALUOp  input  3  ALU operation code (0 add, 1 sub, 2 and, 3 or, 4 eq, 5 le)
- id_rs1, id_rs2  input  RADDR_W  source indices
- id_use_rs1, id_use_rs2  input  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  input  DATA_W  register file read data
- id_imm  input  DATA_W  sign-extended immediate
- id_use_imm  input  1  B operand = immediate instead of rs2
- id_rd  input  RADDR_W  destination index
- id_reg_write, id_mem_read, id_mem_write, id_branch  input  1  control bits
- exmem_rd  input  RADDR_W; exmem_reg_write  input  1; exmem_result  input  DATA_W  EX/MEM forward source
- memwb_rd  input  RADDR_W; memwb_reg_write  input  1; memwb_wdata  input  DATA_W  MEM/WB forward source
- flush  input  1  taken branch resolved in EX; kill instruction entering EX
- stall  output  1  combinational; hold PC and IF/ID this cycle
- ex_valid  output  1  EX holds a real instruction
- ex_ALUOp  output  3; ex_A, ex_B  output  DATA_W  ALU inputs (forwarded)
- ex_store_data  output  DATA_W  forwarded rs2 value for stores
- ex_rd  output  RADDR_W; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1

Behaviour:
- Reset: all stage registers cleared. ex_valid = 0, ex_ALUOp = 0, ex_rd = 0, all control outputs = 0, ex_A = ex_B = ex_store_data = 0, stall = 0.
- Stage registers: valid, ALUOp, rs1/rs2 indices, rs1/rs2 data, imm, use_imm, rd, controls.
- Update priority each edge: rst > flush > stall > load.
  - flush: valid <= 0 and all controls <= 0, regardless of stall.
  - stall: bubble inserted; valid <= 0 and controls <= 0. ID contents are not captured; ID re-presents them next cycle.
  - load: capture all id_* fields; valid <= id_valid.
- When the registered valid = 0, every control output is forced to 0, so a bubble can never write state.
- Load-use stall (combinational):
  - stall = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & !flush.
  - Exactly one stall cycle per hazard. The load then sits in MEM, and MEM/WB forwarding supplies the value in the following EX cycle.
- Forwarding (combinational, per source s in {rs1, rs2}, on the registered indices):
  - EX/MEM wins if exmem_reg_write & exmem_rd != 0 & exmem_rd == s.
  - Otherwise MEM/WB if memwb_reg_write & memwb_rd != 0 & memwb_rd == s.
  - Otherwise the registered data.
  - If s == 0 the value is 0 regardless of data.
- Operand selection:
  - ex_A = fwd_rs1.
  - ex_B = use_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
  - ex_ALUOp = registered ALUOp; 0 (add) when invalid.
- Latency: one cycle from ID capture to ALU inputs. Throughput one instruction per cycle absent stalls.
- Simultaneous flush and stall: flush wins; stall output deasserted.
- Reset mid-stall: next cycle ex_valid = 0 and stall = 0.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 and arbitrary inputs -> ex_valid=0, ex_A=ex_B=0, all controls 0, stall=0.
- Forward priority:
  - Setup: EX holds add with rs1=2, reg data 0x0005. exmem_rd=2, exmem_result=0x1111. memwb_rd=2, memwb_wdata=0x2222. Both write enables 1.
  - Expect ex_A=0x1111. Dropping exmem_reg_write gives 0x2222; dropping both gives 0x0005.
- r0 guard: rs1=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFFFF, reg data 0x1234 -> ex_A=0x0000.
- Load-use: EX holds load with rd=3 (mem_read=1, reg_write=1); ID holds sub using rs2=3.
  - Expect stall=1 for exactly one cycle, then ex_valid=0 (bubble) for one cycle.
  - Then the sub enters EX. With memwb_rd=3, memwb_wdata=0x00A0, expect ex_B=0x00A0.
- Immediate: use_imm=1, imm=0xFFF8, rs2 forwarded 0x0007 -> ex_B=0xFFF8, ex_store_data=0x0007.
- Flush vs stall: assert flush in the same cycle a load-use hazard is present -> stall=0; next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the 16-bit CPU, sitting directly in front of the
// ALU. It captures decoded operands and control from ID, resolves RAW hazards
// by forwarding from EX/MEM and MEM/WB, detects load-use hazards (stalling
// IF/ID and inserting a bubble) and squashes the entering instruction when a
// taken branch is resolved.
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   id_*                : decoded instruction presented by ID
//   exmem_*             : EX/MEM forwarding source (rd, write enable, result)
//   memwb_*             : MEM/WB forwarding source (rd, write enable, data)
//   flush               : taken branch in EX, kill the instruction entering EX
//   stall               : combinational, hold PC and IF/ID this cycle
//   ex_valid            : EX holds a real instruction
//   ex_ALUOp, ex_A/B    : final ALU operation and forwarded operands
//   ex_store_data       : forwarded rs2 value for stores
//   ex_rd, ex_*         : destination index and control bits (0 when invalid)
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               id_valid,
    input  logic [2:0]         id_ALUOp,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [DATA_W-1:0]  id_rs1_data,
    input  logic [DATA_W-1:0]  id_rs2_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_use_imm,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_branch,

    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic [DATA_W-1:0]  exmem_result,

    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    input  logic [DATA_W-1:0]  memwb_wdata,

    input  logic               flush,

    output logic               stall,
    output logic               ex_valid,
    output logic [2:0]         ex_ALUOp,
    output logic [DATA_W-1:0]  ex_A,
    output logic [DATA_W-1:0]  ex_B,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_branch
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_EQ  = 3'd4,
        ALU_LE  = 3'd5
    } alu_op_e;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic               valid_q,     valid_d;
    alu_op_e            aluop_q,     aluop_d;
    logic [RADDR_W-1:0] rs1_q,       rs1_d;
    logic [RADDR_W-1:0] rs2_q,       rs2_d;
    logic [DATA_W-1:0]  rs1_data_q,  rs1_data_d;
    logic [DATA_W-1:0]  rs2_data_q,  rs2_data_d;
    logic [DATA_W-1:0]  imm_q,       imm_d;
    logic               use_imm_q,   use_imm_d;
    logic [RADDR_W-1:0] rd_q,        rd_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               branch_q,    branch_d;

    logic               stall_int;
    logic               hazard_rs1;
    logic               hazard_rs2;
    logic [DATA_W-1:0]  fwd_rs1;
    logic [DATA_W-1:0]  fwd_rs2;

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // The load in EX only has its data after MEM, so a dependent instruction
    // in ID must wait one cycle; MEM/WB forwarding then covers it. A flush
    // kills the instruction in ID anyway, so it never needs to stall. Reset
    // also masks the stall so IF/ID is never held while the pipe is cleared.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in an always_comb gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        stall_int  = 1'b0;

        hazard_rs1 = id_use_rs1 && (id_rs1 == rd_q);
        hazard_rs2 = id_use_rs2 && (id_rs2 == rd_q);

        stall_int = !rst && !flush && id_valid && valid_q && mem_read_q
                  && reg_write_q && (rd_q != '0) && (hazard_rs1 || hazard_rs2);
    end

    // ------------------------------------------------------------------
    // Next-state logic, priority flush > stall > load (rst handled in the
    // register process). A bubble keeps the data fields but clears valid and
    // every control bit, so it can never write architectural state.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d     = valid_q;
        aluop_d     = aluop_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        branch_d    = branch_q;

        if (flush || stall_int) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
        end else begin
            valid_d     = id_valid;
            aluop_d     = alu_op_e'(id_ALUOp);
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            branch_d    = id_branch;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value, independent of statement order.
        if (rst) begin
            // NOTE: the data fields are reset as well as the controls, because
            // the ALU operands must read zero straight after reset.
            valid_q     <= 1'b0;
            aluop_q     <= ALU_ADD;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            aluop_q     <= aluop_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: the younger result (EX/MEM) beats the older one (MEM/WB).
    // r0 is hard-wired to zero, so it is never forwarded and always reads 0.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] forward(
        input logic [RADDR_W-1:0] idx,
        input logic [DATA_W-1:0]  reg_data
    );
        logic [DATA_W-1:0] val;
        val = reg_data;
        if (idx == '0) begin
            val = '0;
        end else if (exmem_reg_write && (exmem_rd == idx)) begin
            val = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == idx)) begin
            val = memwb_wdata;
        end
        return val;
    endfunction

    always_comb begin
        fwd_rs1 = forward(rs1_q, rs1_data_q);
        fwd_rs2 = forward(rs2_q, rs2_data_q);
    end

    // ------------------------------------------------------------------
    // Outputs to the ALU / later stages
    // ------------------------------------------------------------------
    always_comb begin
        stall         = stall_int;
        ex_valid      = valid_q;
        ex_ALUOp      = valid_q ? 3'(aluop_q) : 3'(ALU_ADD);
        ex_A          = fwd_rs1;
        ex_B          = use_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
        ex_rd         = rd_q;
        ex_reg_write  = valid_q && reg_write_q;
        ex_mem_read   = valid_q && mem_read_q;
        ex_mem_write  = valid_q && mem_write_q;
        ex_branch     = valid_q && branch_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage: a table of single-instruction vectors
// (capture, forwarding, operand selection, bubble gating) followed by short
// hand-written sequences for reset, load-use stall, flush-vs-stall and reset
// in the middle of a stall.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_valid;
    logic [2:0]         id_ALUOp;
    logic [RADDR_W-1:0] id_rs1, id_rs2;
    logic               id_use_rs1, id_use_rs2;
    logic [DATA_W-1:0]  id_rs1_data, id_rs2_data, id_imm;
    logic               id_use_imm;
    logic [RADDR_W-1:0] id_rd;
    logic               id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic [RADDR_W-1:0] exmem_rd;
    logic               exmem_reg_write;
    logic [DATA_W-1:0]  exmem_result;
    logic [RADDR_W-1:0] memwb_rd;
    logic               memwb_reg_write;
    logic [DATA_W-1:0]  memwb_wdata;
    logic               flush;

    logic               stall, ex_valid;
    logic [2:0]         ex_ALUOp;
    logic [DATA_W-1:0]  ex_A, ex_B, ex_store_data;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_ALUOp        (id_ALUOp),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_branch       (id_branch),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_wdata     (memwb_wdata),
        .flush           (flush),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .ex_ALUOp        (ex_ALUOp),
        .ex_A            (ex_A),
        .ex_B            (ex_B),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_branch       (ex_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               valid;
        logic [2:0]         aluop;
        logic [RADDR_W-1:0] rs1, rs2;
        logic [DATA_W-1:0]  d1, d2, imm;
        logic               use_imm;
        logic [RADDR_W-1:0] rd;
        logic               rw, mr, mw, br;
        logic [RADDR_W-1:0] em_rd;
        logic               em_rw;
        logic [DATA_W-1:0]  em_res;
        logic [RADDR_W-1:0] mw_rd;
        logic               mw_rw;
        logic [DATA_W-1:0]  mw_dat;
        logic               e_valid;
        logic [2:0]         e_aluop;
        logic [DATA_W-1:0]  e_a, e_b, e_sd;
        logic [RADDR_W-1:0] e_rd;
        logic               e_rw, e_mr, e_mw, e_br;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // mid-cycle, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(
        input logic valid, input logic [2:0] aluop,
        input logic [RADDR_W-1:0] rs1, input logic [RADDR_W-1:0] rs2,
        input logic use1, input logic use2,
        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
        input logic [DATA_W-1:0] imm, input logic use_imm,
        input logic [RADDR_W-1:0] rd,
        input logic rw, input logic mr, input logic mw, input logic br
    );
        id_valid     = valid;   id_ALUOp     = aluop;
        id_rs1       = rs1;     id_rs2       = rs2;
        id_use_rs1   = use1;    id_use_rs2   = use2;
        id_rs1_data  = d1;      id_rs2_data  = d2;
        id_imm       = imm;     id_use_imm   = use_imm;
        id_rd        = rd;
        id_reg_write = rw;      id_mem_read  = mr;
        id_mem_write = mw;      id_branch    = br;
    endtask

    task automatic set_fwd(
        input logic [RADDR_W-1:0] em_rd, input logic em_rw, input logic [DATA_W-1:0] em_res,
        input logic [RADDR_W-1:0] mw_rd, input logic mw_rw, input logic [DATA_W-1:0] mw_dat
    );
        exmem_rd = em_rd; exmem_reg_write = em_rw; exmem_result = em_res;
        memwb_rd = mw_rd; memwb_reg_write = mw_rw; memwb_wdata  = mw_dat;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ex_valid"},      32'(ex_valid),      32'h0);
        check({tag, " ex_ALUOp"},      32'(ex_ALUOp),      32'h0);
        check({tag, " ex_A"},          32'(ex_A),          32'h0);
        check({tag, " ex_B"},          32'(ex_B),          32'h0);
        check({tag, " ex_store_data"}, 32'(ex_store_data), 32'h0);
        check({tag, " ex_rd"},         32'(ex_rd),         32'h0);
        check({tag, " controls"},
              32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 32'h0);
        check({tag, " stall"},         32'(stall),         32'h0);
    endtask

    // Puts a load (r3 <- mem[r1+4]) into EX, leaving ID idle.
    task automatic load_into_ex();
        drive_id(1'b1, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0, 16'h0100, 16'h0000,
                 16'h0004, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        id_valid = 1'b0;
    endtask

    initial begin
        // ---------------- table of directed vectors ----------------
        //   0-2: forwarding priority on rs1 (EX/MEM > MEM/WB > register)
        //   3  : r0 never forwarded
        //   4  : immediate B operand vs forwarded store data
        //   5  : invalid instruction -> controls and ALUOp forced to 0
        //   6  : independent sources forwarded from different stages
        //   7  : MEM/WB write to r0 ignored; non-writing EX/MEM ignored
        vecs[0] = '{valid:1'b1, aluop:3'd0, rs1:3'd2, rs2:3'd4, d1:16'h0005, d2:16'h0009,
                    rd:3'd1, rw:1'b1,
                    em_rd:3'd2, em_rw:1'b1, em_res:16'h1111, mw_rd:3'd2, mw_rw:1'b1, mw_dat:16'h2222,
                    e_valid:1'b1, e_aluop:3'd0, e_a:16'h1111, e_b:16'h0009, e_sd:16'h0009,
                    e_rd:3'd1, e_rw:1'b1, default:'0};
        vecs[1] = vecs[0]; vecs[1].em_rw = 1'b0; vecs[1].e_a = 16'h2222;
        vecs[2] = vecs[1]; vecs[2].mw_rw = 1'b0; vecs[2].e_a = 16'h0005;
        vecs[3] = '{valid:1'b1, aluop:3'd2, rs1:3'd0, rs2:3'd5, d1:16'h1234, d2:16'h0ABC,
                    rd:3'd6, rw:1'b1,
                    em_rd:3'd0, em_rw:1'b1, em_res:16'hFFFF,
                    e_valid:1'b1, e_aluop:3'd2, e_a:16'h0000, e_b:16'h0ABC, e_sd:16'h0ABC,
                    e_rd:3'd6, e_rw:1'b1, default:'0};
        vecs[4] = '{valid:1'b1, aluop:3'd1, rs1:3'd1, rs2:3'd6, d1:16'h0010, d2:16'h0003,
                    imm:16'hFFF8, use_imm:1'b1, rd:3'd0, mw:1'b1,
                    em_rd:3'd6, em_rw:1'b1, em_res:16'h0007, mw_rd:3'd1, mw_rw:1'b1, mw_dat:16'h0020,
                    e_valid:1'b1, e_aluop:3'd1, e_a:16'h0020, e_b:16'hFFF8, e_sd:16'h0007,
                    e_rd:3'd0, e_mw:1'b1, default:'0};
        vecs[5] = '{valid:1'b0, aluop:3'd3, rs1:3'd3, rs2:3'd3, d1:16'h00FF, d2:16'h00FF,
                    rd:3'd7, rw:1'b1, mr:1'b1, mw:1'b1, br:1'b1,
                    e_valid:1'b0, e_aluop:3'd0, e_a:16'h00FF, e_b:16'h00FF, e_sd:16'h00FF,
                    e_rd:3'd7, default:'0};
        vecs[6] = '{valid:1'b1, aluop:3'd5, rs1:3'd4, rs2:3'd3, d1:16'h0001, d2:16'h0002,
                    rd:3'd0, br:1'b1,
                    em_rd:3'd4, em_rw:1'b1, em_res:16'h4444, mw_rd:3'd3, mw_rw:1'b1, mw_dat:16'h3333,
                    e_valid:1'b1, e_aluop:3'd5, e_a:16'h4444, e_b:16'h3333, e_sd:16'h3333,
                    e_rd:3'd0, e_br:1'b1, default:'0};
        vecs[7] = '{valid:1'b1, aluop:3'd4, rs1:3'd0, rs2:3'd2, d1:16'h5555, d2:16'h0001,
                    rd:3'd2, rw:1'b1, mr:1'b1,
                    em_rd:3'd2, em_rw:1'b0, em_res:16'h9999, mw_rd:3'd0, mw_rw:1'b1, mw_dat:16'h7777,
                    e_valid:1'b1, e_aluop:3'd4, e_a:16'h0000, e_b:16'h0001, e_sd:16'h0001,
                    e_rd:3'd2, e_rw:1'b1, e_mr:1'b1, default:'0};

        // ---------------- reset with a live instruction in ID ----------------
        rst   = 1'b1;
        flush = 1'b0;
        drive_id(1'b1, 3'd5, 3'd2, 3'd3, 1'b1, 1'b1, 16'hAAAA, 16'h5555,
                 16'h00F0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        set_fwd(3'd2, 1'b1, 16'hABCD, 3'd3, 1'b1, 16'hBEEF);
        tick();
        #3;
        check_idle_outputs("reset c1");
        tick();
        #3;
        check_idle_outputs("reset c2");
        rst      = 1'b0;
        id_valid = 1'b0;
        set_fwd(3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000);
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            drive_id(vecs[i].valid, vecs[i].aluop, vecs[i].rs1, vecs[i].rs2, 1'b1, 1'b1,
                     vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].use_imm, vecs[i].rd,
                     vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br);
            #2;
            check($sformatf("vec%0d stall", i), 32'(stall), 32'h0);
            tick();
            id_valid = 1'b0;
            set_fwd(vecs[i].em_rd, vecs[i].em_rw, vecs[i].em_res,
                    vecs[i].mw_rd, vecs[i].mw_rw, vecs[i].mw_dat);
            #2;
            check($sformatf("vec%0d ex_valid", i),      32'(ex_valid),      32'(vecs[i].e_valid));
            check($sformatf("vec%0d ex_ALUOp", i),      32'(ex_ALUOp),      32'(vecs[i].e_aluop));
            check($sformatf("vec%0d ex_A", i),          32'(ex_A),          32'(vecs[i].e_a));
            check($sformatf("vec%0d ex_B", i),          32'(ex_B),          32'(vecs[i].e_b));
            check($sformatf("vec%0d ex_store_data", i), 32'(ex_store_data), 32'(vecs[i].e_sd));
            check($sformatf("vec%0d ex_rd", i),         32'(ex_rd),         32'(vecs[i].e_rd));
            check($sformatf("vec%0d ex_reg_write", i),  32'(ex_reg_write),  32'(vecs[i].e_rw));
            check($sformatf("vec%0d ex_mem_read", i),   32'(ex_mem_read),   32'(vecs[i].e_mr));
            check($sformatf("vec%0d ex_mem_write", i),  32'(ex_mem_write),  32'(vecs[i].e_mw));
            check($sformatf("vec%0d ex_branch", i),     32'(ex_branch),     32'(vecs[i].e_br));
        end
        set_fwd(3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000);
        tick();

        // ---------------- load-use: one stall, one bubble, then MEM/WB forward ----------------
        load_into_ex();
        // sub r5 = r4 - r3 (r3 is the load destination; register data is stale)
        drive_id(1'b1, 3'd1, 3'd4, 3'd3, 1'b1, 1'b1, 16'h0040, 16'hDEAD,
                 16'h0000, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check("lu stall", 32'(stall), 32'h1);
        check("lu ex_mem_read", 32'(ex_mem_read), 32'h1);
        tick();
        #2;
        check("lu bubble ex_valid", 32'(ex_valid), 32'h0);
        check("lu bubble ex_reg_write", 32'(ex_reg_write), 32'h0);
        check("lu stall dropped", 32'(stall), 32'h0);
        tick();
        id_valid = 1'b0;
        set_fwd(3'd0, 1'b0, 16'h0000, 3'd3, 1'b1, 16'h00A0);
        #2;
        check("lu sub ex_valid", 32'(ex_valid), 32'h1);
        check("lu sub ex_ALUOp", 32'(ex_ALUOp), 32'h1);
        check("lu sub ex_A", 32'(ex_A), 32'h0040);
        check("lu sub ex_B", 32'(ex_B), 32'h00A0);
        check("lu sub ex_rd", 32'(ex_rd), 32'h5);
        set_fwd(3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000);
        tick();

        // ---------------- no stall when the consumer does not read the load rd ----------------
        load_into_ex();
        drive_id(1'b1, 3'd0, 3'd4, 3'd3, 1'b1, 1'b0, 16'h0001, 16'h0002,
                 16'h0003, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check("unused rs2 no stall", 32'(stall), 32'h0);
        id_valid = 1'b0;
        tick();

        // ---------------- flush beats stall ----------------
        load_into_ex();
        // store mem[r4] <- r3, dependent on the load
        drive_id(1'b1, 3'd0, 3'd4, 3'd3, 1'b1, 1'b1, 16'h0001, 16'h0002,
                 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check("flush pre stall", 32'(stall), 32'h1);
        flush = 1'b1;
        #1;
        check("flush masks stall", 32'(stall), 32'h0);
        tick();
        flush    = 1'b0;
        id_valid = 1'b0;
        #2;
        check("flush ex_valid", 32'(ex_valid), 32'h0);
        check("flush ex_reg_write", 32'(ex_reg_write), 32'h0);
        check("flush ex_mem_write", 32'(ex_mem_write), 32'h0);
        tick();

        // ---------------- reset in the middle of a stall ----------------
        load_into_ex();
        drive_id(1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 1'b0, 16'h0000, 16'h0000,
                 16'h0000, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst-stall pre stall", 32'(stall), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        check("rst-stall ex_valid", 32'(ex_valid), 32'h0);
        check("rst-stall stall", 32'(stall), 32'h0);
        id_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stops advancing.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
